irq_ctrl_n: RTL

Parametrised vectored interrupt controller for the V33-family CPU on the M90/M92-class boards. It latches up to `NUM_IRQ` edge-triggered sources (vblank, hint, sound latch ready, DMA done, and so on) and applies masking and fixed or rotating priority with nesting. It drives the CPU interrupt request and supplies the vector byte during the INTACK cycle. It replaces the fixed `int_vector` tie-off in the board top level and extends it with multiple channels, end-of-interrupt (EOI) modes and a register interface.

---
 rtl/board_pkg.sv | 37 +++
 rtl/irq_prio_enc.sv | 29 ++
 rtl/irq_ctrl_n.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the board interrupt controller: register map,
// acknowledge FSM states and priority arithmetic helpers.
package board_pkg;

    localparam logic [1:0] IRQ_REG_IMR  = 2'd0;
    localparam logic [1:0] IRQ_REG_BASE = 2'd1;
    localparam logic [1:0] IRQ_REG_EOI  = 2'd2;
    localparam logic [1:0] IRQ_REG_MODE = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } irq_state_t;

    // Distance of a level from the highest-priority level hp; 0 is the winner.
    function automatic logic [2:0] irq_rank(input logic [2:0] lvl,
                                            input logic [2:0] hp,
                                            input int         n);
        int t;
        t = int'(lvl) - int'(hp);
        if (t < 0) begin
            t = t + n;
        end
        return 3'(t);
    endfunction

    function automatic logic [2:0] irq_next_level(input logic [2:0] lvl,
                                                  input int         n);
        int t;
        t = int'(lvl) + 1;
        if (t >= n) begin
            t = 0;
        end
        return 3'(t);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational rotating priority encoder: returns the set request bit that
// sits closest to the highest-priority pointer hp (wrapping modulo NUM_IRQ).
module irq_prio_enc
    import board_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] i_req,
    input  logic [2:0]         i_hp,
    output logic               o_valid,
    output logic [2:0]         o_idx
);

    logic [2:0] w_best_rank;

    always_comb begin
        o_valid     = 1'b0;
        o_idx       = 3'd0;
        w_best_rank = 3'd7;
        for (int j = 0; j < NUM_IRQ; j++) begin
            if (i_req[j] && (!o_valid || (irq_rank(3'(j), i_hp, NUM_IRQ) < w_best_rank))) begin
                o_valid     = 1'b1;
                o_idx       = 3'(j);
                w_best_rank = irq_rank(3'(j), i_hp, NUM_IRQ);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl_n.sv
// Vectored interrupt controller: edge latching into IRR, masking, fixed or
// rotating priority with nesting, INTACK vector delivery and EOI handling.
module irq_ctrl_n
    import board_pkg::*;
#(
    parameter int         NUM_IRQ      = 4,
    parameter logic [7:0] DEFAULT_BASE = 8'h20,
    parameter bit         AUTO_EOI     = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               reg_wr,
    input  logic [1:0]         reg_addr,
    input  logic [7:0]         reg_din,
    output logic [7:0]         reg_dout,
    input  logic               intak,
    output logic               int_req,
    output logic [7:0]         vector
);

    localparam logic [NUM_IRQ-1:0] ONE_HOT0     = NUM_IRQ'(1);
    localparam logic [7:0]         SPURIOUS_OFS = 8'(NUM_IRQ - 1);

    logic [NUM_IRQ-1:0] r_imr;
    logic [NUM_IRQ-1:0] r_irr;
    logic [NUM_IRQ-1:0] r_isr;
    logic [NUM_IRQ-1:0] r_irq_hist;
    logic [7:0]         r_base;
    logic [7:0]         r_vector;
    logic [7:0]         r_dout;
    logic [1:0]         r_mode;
    logic [2:0]         r_hp;
    logic [2:0]         r_cur;
    logic               r_spur;
    logic               r_intak_d;
    logic               r_int_req;
    irq_state_t         r_state;

    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_cand_req;
    logic [NUM_IRQ-1:0] w_ack_clr;
    logic [NUM_IRQ-1:0] w_eoi_clr;
    logic [NUM_IRQ-1:0] w_auto_clr;
    logic [2:0]         w_prio_hp;
    logic [2:0]         w_cand_idx;
    logic [2:0]         w_isr_idx;
    logic [2:0]         w_hp_next;
    logic               w_cand_valid;
    logic               w_isr_valid;
    logic               w_req_cond;
    logic               w_intak_rise;
    logic               w_intak_fall;
    logic               w_ack;
    logic               w_eoi;
    logic               w_auto_eoi;
    logic               w_unused_din;

    assign w_unused_din = ^reg_din;

    assign w_edge       = ce ? (irq_in & ~r_irq_hist) : '0;
    assign w_cand_req   = r_irr & ~r_imr;
    // Fixed mode is rotating priority with the pointer pinned at level 0.
    assign w_prio_hp    = r_mode[1] ? r_hp : 3'd0;
    assign w_intak_rise = intak & ~r_intak_d;
    assign w_intak_fall = ~intak & r_intak_d;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_cand_enc (
        .i_req   (w_cand_req),
        .i_hp    (w_prio_hp),
        .o_valid (w_cand_valid),
        .o_idx   (w_cand_idx)
    );

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_isr_enc (
        .i_req   (r_isr),
        .i_hp    (w_prio_hp),
        .o_valid (w_isr_valid),
        .o_idx   (w_isr_idx)
    );

    assign w_req_cond = w_cand_valid &&
                        (!w_isr_valid ||
                         (irq_rank(w_cand_idx, w_prio_hp, NUM_IRQ) <
                          irq_rank(w_isr_idx, w_prio_hp, NUM_IRQ)));

    assign w_ack      = (r_state == IDLE) && w_intak_rise;
    assign w_eoi      = reg_wr && (reg_addr == IRQ_REG_EOI) && w_isr_valid;
    assign w_auto_eoi = (r_state == ACK) && w_intak_fall && r_mode[0] && !r_spur;

    assign w_ack_clr  = (w_ack && w_cand_valid) ? (ONE_HOT0 << w_cand_idx) : '0;
    assign w_eoi_clr  = w_eoi ? (ONE_HOT0 << w_isr_idx) : '0;
    assign w_auto_clr = w_auto_eoi ? (ONE_HOT0 << r_cur) : '0;

    // An explicit EOI and an auto-EOI in the same cycle: auto-EOI is applied last.
    always_comb begin
        w_hp_next = r_hp;
        if (w_auto_eoi) begin
            w_hp_next = irq_next_level(r_cur, NUM_IRQ);
        end else if (w_eoi) begin
            w_hp_next = irq_next_level(w_isr_idx, NUM_IRQ);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_imr      <= '1;
            r_base     <= DEFAULT_BASE;
            r_mode     <= {1'b0, AUTO_EOI};
            r_irr      <= '0;
            r_isr      <= '0;
            r_hp       <= 3'd0;
            r_irq_hist <= irq_in;
            r_intak_d  <= intak;
            r_dout     <= 8'd0;
        end else begin
            r_intak_d <= intak;
            if (ce) begin
                r_irq_hist <= irq_in;
            end
            // A fresh edge wins over the acknowledge clearing the same bit.
            r_irr <= (r_irr & ~w_ack_clr) | w_edge;
            r_isr <= (r_isr | w_ack_clr) & ~w_eoi_clr & ~w_auto_clr;
            r_hp  <= w_hp_next;
            if (reg_wr) begin
                case (reg_addr)
                    IRQ_REG_IMR:  r_imr  <= reg_din[NUM_IRQ-1:0];
                    IRQ_REG_BASE: r_base <= reg_din;
                    IRQ_REG_MODE: r_mode <= reg_din[1:0];
                    default:      ;
                endcase
            end
            case (reg_addr)
                IRQ_REG_IMR:  r_dout <= 8'(r_imr);
                IRQ_REG_BASE: r_dout <= r_base;
                IRQ_REG_EOI:  r_dout <= 8'(r_irr);
                default:      r_dout <= 8'(r_isr);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cur     <= 3'd0;
            r_spur    <= 1'b0;
            r_vector  <= DEFAULT_BASE;
            r_int_req <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_int_req <= w_intak_rise ? 1'b0 : w_req_cond;
                    if (w_intak_rise) begin
                        r_state  <= ACK;
                        r_cur    <= w_cand_idx;
                        r_spur   <= !w_cand_valid;
                        r_vector <= w_cand_valid ? (r_base + {5'd0, w_cand_idx})
                                                 : (r_base + SPURIOUS_OFS);
                    end
                end
                ACK: begin
                    r_int_req <= 1'b0;
                    if (w_intak_fall) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_int_req <= 1'b0;
                end
            endcase
        end
    end

    assign reg_dout = r_dout;
    assign int_req  = r_int_req;
    assign vector   = r_vector;

endmodule
